// File: rtl/shift_reg_scheduler_if.sv
// Requester / shift-register side of the shared serial-in register scheduler.
// The scheduler connects through the slave modport, its environment through master.
interface shift_reg_scheduler_if #(
   parameter int WIDTH = 4
);
   logic [1:0]       Req;
   logic [WIDTH-1:0] Data0;
   logic [WIDTH-1:0] Data1;
   logic [WIDTH-1:0] X_in;
   logic [1:0]       Gnt;
   logic             SO;
   logic             Shift;
   logic             Busy;
   logic             Owner;
   logic [WIDTH-1:0] Result;
   logic             Match;
   logic             Done;

   modport master (
      output Req, Data0, Data1, X_in,
      input  Gnt, SO, Shift, Busy, Owner, Result, Match, Done
   );

   modport slave (
      input  Req, Data0, Data1, X_in,
      output Gnt, SO, Shift, Busy, Owner, Result, Match, Done
   );
endinterface

// File: rtl/shift_reg_scheduler.sv
// Round-robin scheduler that serialises one of two requester words MSB-first
// into a shared shift register, then checks the parallel readback.
module shift_reg_scheduler #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic                   Clk,
   input  logic                   Rst,
   shift_reg_scheduler_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      CHECK,
      GAPS
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sent;
   logic [CW-1:0]    cnt;
   logic [GW-1:0]    gcnt;
   logic             last_srv;
   logic             pick;
   logic [WIDTH-1:0] data_sel;

   // On contention the requester that was not served last wins
   always_comb begin
      pick = bus.Req[1];
      if (bus.Req == 2'b11) pick = ~last_srv;
   end

   always_comb begin
      data_sel = bus.Data0;
      if (bus.Owner) data_sel = bus.Data1;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state      <= IDLE;
         sreg       <= '0;
         sent       <= '0;
         cnt        <= '0;
         gcnt       <= '0;
         last_srv   <= 1'b1;
         bus.Gnt    <= '0;
         bus.SO     <= 1'b0;
         bus.Shift  <= 1'b0;
         bus.Busy   <= 1'b0;
         bus.Owner  <= 1'b0;
         bus.Result <= '0;
         bus.Match  <= 1'b0;
         bus.Done   <= 1'b0;
      end else begin
         bus.Gnt  <= '0;
         bus.Done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|bus.Req) begin
                  state     <= LOAD;
                  bus.Busy  <= 1'b1;
                  bus.Owner <= pick;
                  bus.Gnt   <= pick ? 2'b10 : 2'b01;
               end
            end
            // SO/Shift are set one edge early so they are valid in SHIFT
            LOAD: begin
               sent      <= data_sel;
               sreg      <= data_sel << 1;
               bus.SO    <= data_sel[WIDTH-1];
               bus.Shift <= 1'b1;
               cnt       <= '0;
               state     <= SHIFT;
            end
            SHIFT: begin
               if (cnt == CW'(WIDTH - 1)) begin
                  bus.Shift <= 1'b0;
                  bus.SO    <= 1'b0;
                  state     <= CHECK;
               end else begin
                  cnt    <= cnt + 1'b1;
                  bus.SO <= sreg[WIDTH-1];
                  sreg   <= sreg << 1;
               end
            end
            CHECK: begin
               bus.Result <= bus.X_in;
               bus.Match  <= (bus.X_in == sent);
               bus.Done   <= 1'b1;
               last_srv   <= bus.Owner;
               gcnt       <= '0;
               state      <= GAPS;
            end
            GAPS: begin
               if (gcnt == GW'(GAP - 1)) begin
                  bus.Busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shift_reg_scheduler.sv
// Directed bench: 4-bit/GAP=1 instance driven from a vector table plus
// hand sequences for reset abort and an 8-bit/GAP=3 instance.
module tb_shift_reg_scheduler;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_gnt = 0;
   logic corrupt = 1'b0;
   logic [3:0] x4 = '0;
   logic [7:0] x8 = '0;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   shift_reg_scheduler_if #(.WIDTH(4)) b4 ();
   shift_reg_scheduler_if #(.WIDTH(8)) b8 ();

   shift_reg_scheduler #(.WIDTH(4), .GAP(1)) u4 (
      .Clk (Clk),
      .Rst (Rst),
      .bus (b4.slave)
   );

   shift_reg_scheduler #(.WIDTH(8), .GAP(3)) u8 (
      .Clk (Clk),
      .Rst (Rst),
      .bus (b8.slave)
   );

   // Loopback shift registers; first bit shifted in ends up at the MSB
   always @(posedge Clk) if (b4.Shift) x4 <= {x4[2:0], b4.SO};
   always @(posedge Clk) if (b8.Shift) x8 <= {x8[6:0], b8.SO};
   assign b4.X_in = x4 ^ (corrupt ? 4'b0100 : 4'b0000);
   assign b8.X_in = x8;

   typedef struct {
      logic       pre_rst;
      logic [1:0] req;
      logic [1:0] after;
      logic [3:0] d0;
      logic [3:0] d1;
      logic       corrupt;
      logic [1:0] gnt;
      logic [3:0] res;
      logic       match;
      logic       spacing;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run(vec_t v);
      logic [3:0] so;
      logic [3:0] word;
      int nsh;
      if (v.pre_rst) begin
         Rst = 1'b1;
         b4.Req = 2'b00;
         @(negedge Clk);
         Rst = 1'b0;
         @(negedge Clk);
      end
      word = v.gnt[1] ? v.d1 : v.d0;
      b4.Req = v.req;
      b4.Data0 = v.d0;
      b4.Data1 = v.d1;
      corrupt = v.corrupt;
      @(negedge Clk);
      chk("gnt", b4.Gnt, v.gnt);
      chk("owner_at_gnt", b4.Owner, v.gnt[1]);
      chk("busy_load", b4.Busy, 1);
      if (v.spacing) chk("gnt_spacing", cyc - last_gnt, 8);
      last_gnt = cyc;
      so = '0;
      nsh = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         nsh += int'(b4.Shift);
         so = {so[2:0], b4.SO};
         if (i == 0) b4.Req = v.after;
      end
      chk("shift_cycles", nsh, 4);
      chk("so_pattern", so, word);
      @(negedge Clk);
      chk("check_idle_out", {b4.Shift, b4.SO, b4.Done, b4.Gnt}, 0);
      @(negedge Clk);
      chk("done", b4.Done, 1);
      chk("result", b4.Result, v.res);
      chk("match", b4.Match, v.match);
      chk("owner", b4.Owner, v.gnt[1]);
      chk("busy_gap", b4.Busy, 1);
      corrupt = 1'b0;
      @(negedge Clk);
      chk("idle_after", {b4.Busy, b4.Done, b4.Gnt}, 0);
   endtask

   initial begin
      vec_t v;
      logic [7:0] so8;
      logic [2:0] dpat;
      int nsh;
      int nbusy;
      logic seen_done;
      logic seen_busy;

      //          rst   req    after  d0     d1     cor   gnt    res    m     sp
      vecs[0] = '{1'b0, 2'b01, 2'b00, 4'hB, 4'h0, 1'b0, 2'b01, 4'hB, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 2'b11, 2'b11, 4'h3, 4'hC, 1'b0, 2'b01, 4'h3, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 2'b11, 2'b11, 4'h3, 4'hC, 1'b0, 2'b10, 4'hC, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 2'b11, 2'b11, 4'h3, 4'hC, 1'b0, 2'b01, 4'h3, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 2'b11, 2'b00, 4'h3, 4'hC, 1'b0, 2'b10, 4'hC, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 2'b10, 2'b00, 4'h0, 4'h6, 1'b0, 2'b10, 4'h6, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 2'b01, 2'b00, 4'h9, 4'h0, 1'b1, 2'b01, 4'hD, 1'b0, 1'b0};

      b4.Req = 2'b00;
      b4.Data0 = '0;
      b4.Data1 = '0;
      b8.Req = 2'b00;
      b8.Data0 = '0;
      b8.Data1 = '0;
      repeat (2) @(negedge Clk);
      chk("reset_out4", {b4.Gnt, b4.SO, b4.Shift, b4.Busy, b4.Owner,
                         b4.Result, b4.Match, b4.Done}, 0);
      chk("reset_out8", {b8.Gnt, b8.SO, b8.Shift, b8.Busy, b8.Owner,
                         b8.Result, b8.Match, b8.Done}, 0);
      Rst = 1'b0;
      @(negedge Clk);

      for (int k = 0; k < 7; k++) run(vecs[k]);

      // Reset in the second SHIFT cycle aborts without a Done
      b4.Req = 2'b01;
      b4.Data0 = 4'hB;
      repeat (3) @(negedge Clk);
      chk("pre_rst_shift", b4.Shift, 1);
      Rst = 1'b1;
      b4.Req = 2'b00;
      #1;
      chk("async_rst_out", {b4.Gnt, b4.SO, b4.Shift, b4.Busy, b4.Owner,
                            b4.Result, b4.Match, b4.Done}, 0);
      @(negedge Clk);
      Rst = 1'b0;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      repeat (8) begin
         @(negedge Clk);
         seen_done |= b4.Done;
         seen_busy |= b4.Busy;
      end
      chk("no_done_after_rst", seen_done, 0);
      chk("no_busy_after_rst", seen_busy, 0);
      v = '{1'b0, 2'b11, 2'b00, 4'h3, 4'hC, 1'b0, 2'b01, 4'h3, 1'b1, 1'b0};
      run(v);

      // WIDTH=8, GAP=3 instance
      b8.Req = 2'b01;
      b8.Data0 = 8'hA5;
      @(negedge Clk);
      chk("w8_gnt", b8.Gnt, 2'b01);
      so8 = '0;
      nsh = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         nsh += int'(b8.Shift);
         so8 = {so8[6:0], b8.SO};
         if (i == 0) b8.Req = 2'b00;
      end
      chk("w8_shift_cycles", nsh, 8);
      chk("w8_so_pattern", so8, 8'hA5);
      @(negedge Clk);
      chk("w8_check", {b8.Shift, b8.Done}, 0);
      dpat = '0;
      nbusy = 0;
      for (int g = 0; g < 3; g++) begin
         @(negedge Clk);
         dpat = {dpat[1:0], b8.Done};
         nbusy += int'(b8.Busy);
         if (g == 0) begin
            chk("w8_result", b8.Result, 8'hA5);
            chk("w8_match", b8.Match, 1);
         end
      end
      chk("w8_done_pattern", dpat, 3'b100);
      chk("w8_gap_busy", nbusy, 3);
      @(negedge Clk);
      chk("w8_idle", {b8.Busy, b8.Done}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
